// File: rtl/fdc_sector_ring_if.sv
// Producer/consumer bus of fdc_sector_ring: byte stream in, random-read head sector out.
// master = the side driving requests (loader + FDC core), slave = the ring itself.
interface fdc_sector_ring_if #(
    parameter int DATA_W    = 8,
    parameter int SECTOR_AW = 9,
    parameter int NUM_SLOTS = 4
);
    localparam int SLOT_W = $clog2(NUM_SLOTS);

    logic                 flush;
    logic                 wr_valid;
    logic [DATA_W-1:0]    wr_data;
    logic                 wr_ready;
    logic                 wr_abort;
    logic                 rd_avail;
    logic [SLOT_W:0]      rd_count;
    logic                 rd_en;
    logic [SECTOR_AW-1:0] rd_addr;
    logic [DATA_W-1:0]    rd_data;
    logic                 rd_data_valid;
    logic                 rd_release;

    modport master (
        output flush, wr_valid, wr_data, wr_abort, rd_en, rd_addr, rd_release,
        input  wr_ready, rd_avail, rd_count, rd_data, rd_data_valid
    );
    modport slave (
        input  flush, wr_valid, wr_data, wr_abort, rd_en, rd_addr, rd_release,
        output wr_ready, rd_avail, rd_count, rd_data, rd_data_valid
    );
endinterface

// File: rtl/fdc_sector_ring.sv
// Ring of NUM_SLOTS sector buffers in one inferred RAM; producer auto-commits full sectors,
// consumer random-reads the oldest one. Define FDC_RING_OREG_EN for a RAM output register (latency 2).
module fdc_sector_ring #(
    parameter int DATA_W    = 8,
    parameter int SECTOR_AW = 9,
    parameter int NUM_SLOTS = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    fdc_sector_ring_if.slave bus
);
    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int DEPTH  = NUM_SLOTS * (2 ** SECTOR_AW);
    localparam logic [SLOT_W:0] FULL = (SLOT_W+1)'(NUM_SLOTS);
`ifdef FDC_RING_OREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic [DATA_W-1:0]    r_mem [DEPTH];
    logic [SECTOR_AW-1:0] r_wr_ptr;
    logic [SLOT_W-1:0]    r_wr_slot, r_rd_slot;
    logic [SLOT_W:0]      r_count;
    logic [DATA_W-1:0]    r_rd_data;
    logic [LAT-1:0]       r_vld_pipe;
    logic w_wr_ready, w_rd_avail, w_wr_fire, w_commit, w_rd_fire, w_release;

    assign w_wr_ready = (r_count < FULL);
    assign w_rd_avail = (r_count != '0);
    // abort and flush both drop a same-cycle transfer
    assign w_wr_fire  = bus.wr_valid & w_wr_ready & ~bus.wr_abort & ~bus.flush;
    assign w_commit   = w_wr_fire & (&r_wr_ptr);
    assign w_rd_fire  = bus.rd_en & w_rd_avail & ~bus.flush;
    assign w_release  = bus.rd_release & w_rd_avail & ~bus.flush;

    always_ff @(posedge clk) begin
        if (w_wr_fire) r_mem[{r_wr_slot, r_wr_ptr}] <= bus.wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr  <= '0;
            r_wr_slot <= '0;
            r_rd_slot <= '0;
            r_count   <= '0;
        end else if (bus.flush) begin
            r_wr_ptr  <= '0;
            r_wr_slot <= '0;
            r_rd_slot <= '0;
            r_count   <= '0;
        end else begin
            if (bus.wr_abort)  r_wr_ptr <= '0;
            else if (w_wr_fire) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_commit)  r_wr_slot <= r_wr_slot + 1'b1;
            if (w_release) r_rd_slot <= r_rd_slot + 1'b1;
            case ({w_commit, w_release})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_vld_pipe <= '0;
        else if (bus.flush) r_vld_pipe <= '0;
        else r_vld_pipe <= LAT'({r_vld_pipe, w_rd_fire});
    end

`ifdef FDC_RING_OREG_EN
    logic [DATA_W-1:0] r_ram_q;

    // the RAM stage already holds the old head's word, so a following release cannot disturb it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ram_q   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_rd_fire) r_ram_q <= r_mem[{r_rd_slot, bus.rd_addr}];
            if (r_vld_pipe[0] && !bus.flush) r_rd_data <= r_ram_q;
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rd_data <= '0;
        else if (w_rd_fire) r_rd_data <= r_mem[{r_rd_slot, bus.rd_addr}];
    end
`endif

    assign bus.wr_ready      = w_wr_ready;
    assign bus.rd_avail      = w_rd_avail;
    assign bus.rd_count      = r_count;
    assign bus.rd_data       = r_rd_data;
    assign bus.rd_data_valid = r_vld_pipe[LAT-1];
endmodule

// File: tb/tb_fdc_sector_ring.sv
// Bench for fdc_sector_ring: committed sectors modelled as one word queue (head sector first),
// the open sector as a second queue, read latency as a FIFO of pending results.
module tb_fdc_sector_ring;
`ifdef FDC_RING_OREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int SW = 512;

    typedef struct packed { logic v; logic [7:0] d; } rd_t;

    logic clk, reset_n;
    fdc_sector_ring_if #(.DATA_W(8), .SECTOR_AW(9), .NUM_SLOTS(4)) bus();

    fdc_sector_ring #(.DATA_W(8), .SECTOR_AW(9), .NUM_SLOTS(4)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] cq[$];
    logic [7:0] pq[$];
    rd_t        rpipe[$];
    logic       exp_vld;
    logic [7:0] exp_data;
    int n_cmp = 0, n_err = 0;

    function automatic int mcount();
        return cq.size() / SW;
    endfunction

    task automatic idle();
        bus.flush = 0; bus.wr_valid = 0; bus.wr_data = 0; bus.wr_abort = 0;
        bus.rd_en = 0; bus.rd_addr = 0; bus.rd_release = 0;
    endtask

    // one clock: reference model consumes the inputs as they stand before the edge
    task automatic step();
        int cnt; logic rdy, av, fl, wv, ab, rl; logic [7:0] wd; rd_t nr;
        cnt = mcount(); rdy = cnt < 4; av = cnt != 0;
        fl = bus.flush; wv = bus.wr_valid; ab = bus.wr_abort; rl = bus.rd_release; wd = bus.wr_data;
        nr = '0;
        if (bus.rd_en && av && !fl) begin nr.v = 1'b1; nr.d = cq[bus.rd_addr]; end
        @(posedge clk);
        if (fl) begin
            cq.delete(); pq.delete();
            foreach (rpipe[i]) rpipe[i].v = 1'b0;
        end else begin
            if (ab) pq.delete();
            else if (wv && rdy) pq.push_back(wd);
            if (rl && av) repeat (SW) void'(cq.pop_front());
            if (pq.size() == SW) begin cq = {cq, pq}; pq.delete(); end
        end
        rpipe.push_back(nr);
        nr = rpipe.pop_front();
        exp_vld = nr.v;
        if (nr.v) exp_data = nr.d;
        #1;
    endtask

    task automatic put(input logic [7:0] d);
        bus.wr_valid = 1'b1; bus.wr_data = d; step();
    endtask

    task automatic model_reset();
        cq.delete(); pq.delete(); rpipe.delete();
        repeat (LAT-1) rpipe.push_back('0);
        exp_vld = 1'b0; exp_data = 8'h00;
    endtask

    task automatic test_reset();
        idle(); reset_n = 1'b0; model_reset();
        #1;
        n_cmp++; if (bus.rd_data !== 8'h00) begin n_err++; $display("FAIL rst_rd_data got=%h exp=00", bus.rd_data); end
        n_cmp++; if (bus.rd_data_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", bus.rd_data_valid); end
        n_cmp++; if (bus.rd_avail !== 1'b0) begin n_err++; $display("FAIL rst_avail got=%b exp=0", bus.rd_avail); end
        n_cmp++; if (bus.rd_count !== 3'd0) begin n_err++; $display("FAIL rst_count got=%0d exp=0", bus.rd_count); end
        n_cmp++; if (bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got=%b exp=1", bus.wr_ready); end
        @(posedge clk); #1; reset_n = 1'b1;
    endtask

    task automatic test_stream();
        for (int i = 0; i < SW; i++) begin
            put(8'(i));
            if (i == SW-2) begin
                n_cmp++; if (bus.rd_count !== 3'd0) begin n_err++; $display("FAIL stream_pre_count got=%0d exp=0", bus.rd_count); end
            end
        end
        idle();
        n_cmp++; if (bus.rd_count !== 3'd1) begin n_err++; $display("FAIL stream_count got=%0d exp=1", bus.rd_count); end
        bus.rd_en = 1'b1; bus.rd_addr = 9'h1FF; step(); bus.rd_en = 1'b0;
        repeat (LAT-1) begin
            n_cmp++; if (bus.rd_data_valid !== 1'b0) begin n_err++; $display("FAIL stream_early_valid got=%b exp=0", bus.rd_data_valid); end
            step();
        end
        n_cmp++; if (bus.rd_data_valid !== 1'b1 || bus.rd_data !== 8'hFF)
            begin n_err++; $display("FAIL stream_last v/d got=%b/%h exp=1/ff", bus.rd_data_valid, bus.rd_data); end
        step();
        n_cmp++; if (bus.rd_data_valid !== 1'b0 || bus.rd_data !== 8'hFF)
            begin n_err++; $display("FAIL stream_hold v/d got=%b/%h exp=0/ff", bus.rd_data_valid, bus.rd_data); end
        for (int i = 0; i < 24 + LAT; i++) begin
            bus.rd_en = (i < 24); bus.rd_addr = 9'($urandom); step();
            n_cmp++; if (bus.rd_data_valid !== exp_vld || bus.rd_data !== exp_data)
                begin n_err++; $display("FAIL stream_rand v/d got=%b/%h exp=%b/%h", bus.rd_data_valid, bus.rd_data, exp_vld, exp_data); end
        end
        idle();
    endtask

    task automatic test_full();
        idle(); bus.flush = 1'b1; step(); idle();
        for (int k = 0; k < 4; k++) for (int i = 0; i < SW; i++) put(8'(k));
        idle();
        n_cmp++; if (bus.wr_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got=%b exp=0", bus.wr_ready); end
        n_cmp++; if (bus.rd_count !== 3'd4) begin n_err++; $display("FAIL full_count got=%0d exp=4", bus.rd_count); end
        for (int i = 0; i < 20; i++) put(8'hEE);
        bus.rd_release = 1'b1; step(); idle();
        n_cmp++; if (bus.rd_count !== 3'd3) begin n_err++; $display("FAIL full_rel_count got=%0d exp=3", bus.rd_count); end
        n_cmp++; if (bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL full_rel_ready got=%b exp=1", bus.wr_ready); end
        bus.rd_en = 1'b1; bus.rd_addr = 9'($urandom); step(); bus.rd_en = 1'b0;
        repeat (LAT-1) step();
        n_cmp++; if (bus.rd_data_valid !== 1'b1 || bus.rd_data !== 8'd1)
            begin n_err++; $display("FAIL full_head1 v/d got=%b/%h exp=1/01", bus.rd_data_valid, bus.rd_data); end
        for (int i = 0; i < SW; i++) put(8'($urandom));
        idle();
        n_cmp++; if (bus.rd_count !== 3'd4) begin n_err++; $display("FAIL refill_count got=%0d exp=4", bus.rd_count); end
        bus.rd_release = 1'b1; repeat (3) step(); idle();
        for (int i = 0; i < 16 + LAT; i++) begin
            bus.rd_en = (i < 16); bus.rd_addr = 9'($urandom); step();
            n_cmp++; if (bus.rd_data_valid !== exp_vld || bus.rd_data !== exp_data)
                begin n_err++; $display("FAIL refill_rd v/d got=%b/%h exp=%b/%h", bus.rd_data_valid, bus.rd_data, exp_vld, exp_data); end
        end
        idle();
    endtask

    task automatic test_commit_release();
        idle(); bus.flush = 1'b1; step(); idle();
        for (int i = 0; i < 3*SW - 1; i++) put(8'($urandom));
        bus.rd_release = 1'b1; put(8'($urandom)); idle();
        n_cmp++; if (bus.rd_count !== 3'd2) begin n_err++; $display("FAIL cr_count got=%0d exp=2", bus.rd_count); end
        for (int i = 0; i < 12 + LAT; i++) begin
            bus.rd_en = (i < 12); bus.rd_addr = 9'($urandom); step();
            n_cmp++; if (bus.rd_data_valid !== exp_vld || bus.rd_data !== exp_data)
                begin n_err++; $display("FAIL cr_head v/d got=%b/%h exp=%b/%h", bus.rd_data_valid, bus.rd_data, exp_vld, exp_data); end
        end
        idle(); bus.rd_release = 1'b1; step(); idle();
        for (int i = 0; i < 12 + LAT; i++) begin
            bus.rd_en = (i < 12); bus.rd_addr = 9'($urandom); step();
            n_cmp++; if (bus.rd_data_valid !== exp_vld || bus.rd_data !== exp_data)
                begin n_err++; $display("FAIL cr_next v/d got=%b/%h exp=%b/%h", bus.rd_data_valid, bus.rd_data, exp_vld, exp_data); end
        end
        idle();
    endtask

    task automatic test_abort();
        idle(); bus.flush = 1'b1; step(); idle();
        for (int i = 0; i < 100; i++) put(8'($urandom));
        bus.wr_abort = 1'b1; put(8'h5A); idle();
        for (int i = 0; i < SW; i++) put(8'hA5);
        idle();
        n_cmp++; if (bus.rd_count !== 3'd1) begin n_err++; $display("FAIL abort_count got=%0d exp=1", bus.rd_count); end
        for (int i = 0; i < 20 + LAT; i++) begin
            bus.rd_en = (i < 20); bus.rd_addr = (i == 0) ? 9'h000 : (i == 1) ? 9'h1FF : 9'($urandom); step();
            if (exp_vld) begin
                n_cmp++; if (bus.rd_data_valid !== 1'b1 || bus.rd_data !== 8'hA5)
                    begin n_err++; $display("FAIL abort_data v/d got=%b/%h exp=1/a5", bus.rd_data_valid, bus.rd_data); end
            end
        end
        idle();
    endtask

    task automatic test_empty_flush();
        idle(); bus.flush = 1'b1; step(); idle();
        bus.rd_en = 1'b1; bus.rd_release = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.rd_addr = 9'($urandom); step();
            n_cmp++; if (bus.rd_data_valid !== 1'b0 || bus.rd_count !== 3'd0 || bus.rd_data !== exp_data)
                begin n_err++; $display("FAIL empty v/cnt/d got=%b/%0d/%h exp=0/0/%h", bus.rd_data_valid, bus.rd_count, bus.rd_data, exp_data); end
        end
        idle();
        for (int i = 0; i < 3*SW; i++) put(8'($urandom));
        idle();
        n_cmp++; if (bus.rd_count !== 3'd3) begin n_err++; $display("FAIL fl_pre_count got=%0d exp=3", bus.rd_count); end
        bus.rd_en = 1'b1; bus.rd_addr = 9'($urandom); step();
        bus.flush = 1'b1; step(); idle();
        n_cmp++; if (bus.rd_avail !== 1'b0 || bus.rd_count !== 3'd0)
            begin n_err++; $display("FAIL flush avail/cnt got=%b/%0d exp=0/0", bus.rd_avail, bus.rd_count); end
        n_cmp++; if (bus.rd_data_valid !== exp_vld || bus.rd_data !== exp_data)
            begin n_err++; $display("FAIL flush_rd v/d got=%b/%h exp=%b/%h", bus.rd_data_valid, bus.rd_data, exp_vld, exp_data); end
    endtask

    task automatic test_async_reset();
        idle();
        for (int i = 0; i < SW; i++) put(8'($urandom) | 8'h01);
        bus.rd_en = 1'b1; bus.rd_addr = 9'($urandom);
        for (int i = 0; i < 37; i++) put(8'($urandom));
        #2; reset_n = 1'b0; model_reset(); #1;
        n_cmp++; if (bus.rd_data !== 8'h00 || bus.rd_data_valid !== 1'b0)
            begin n_err++; $display("FAIL arst_rd v/d got=%b/%h exp=0/00", bus.rd_data_valid, bus.rd_data); end
        n_cmp++; if (bus.rd_avail !== 1'b0 || bus.rd_count !== 3'd0 || bus.wr_ready !== 1'b1)
            begin n_err++; $display("FAIL arst_status av/cnt/rdy got=%b/%0d/%b exp=0/0/1", bus.rd_avail, bus.rd_count, bus.wr_ready); end
        idle(); @(posedge clk); #1; reset_n = 1'b1;
        for (int i = 0; i < SW; i++) put(8'($urandom));
        idle();
        bus.rd_en = 1'b1;
        for (int i = 0; i < 8 + LAT; i++) begin
            bus.rd_en = (i < 8); bus.rd_addr = (i == 0) ? 9'h000 : 9'($urandom); step();
            n_cmp++; if (bus.rd_data_valid !== exp_vld || bus.rd_data !== exp_data)
                begin n_err++; $display("FAIL arst_after v/d got=%b/%h exp=%b/%h", bus.rd_data_valid, bus.rd_data, exp_vld, exp_data); end
        end
        idle();
    endtask

    task automatic test_back_to_back();
        idle(); bus.flush = 1'b1; step(); idle();
        for (int c = 0; c < 6000; c++) begin
            bus.wr_valid   = ($urandom_range(3) != 0);
            bus.wr_data    = 8'($urandom);
            bus.wr_abort   = ($urandom_range(999) == 0);
            bus.rd_en      = $urandom_range(1) == 1;
            bus.rd_addr    = 9'($urandom);
            bus.rd_release = ($urandom_range(399) == 0);
            bus.flush      = ($urandom_range(2999) == 0);
            step();
            n_cmp++; if (bus.rd_data_valid !== exp_vld || bus.rd_data !== exp_data)
                begin n_err++; $display("FAIL b2b_rd cyc=%0d v/d got=%b/%h exp=%b/%h", c, bus.rd_data_valid, bus.rd_data, exp_vld, exp_data); end
            n_cmp++; if (bus.rd_count !== 3'(mcount()) || bus.wr_ready !== (mcount() < 4) || bus.rd_avail !== (mcount() != 0))
                begin n_err++; $display("FAIL b2b_status cyc=%0d cnt/rdy/av got=%0d/%b/%b exp=%0d", c, bus.rd_count, bus.wr_ready, bus.rd_avail, mcount()); end
        end
        idle();
    endtask

    initial begin
        reset_n = 1'b0; idle(); model_reset();
        test_reset();
        test_stream();
        test_full();
        test_commit_release();
        test_abort();
        test_empty_flush();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
